// File: rtl/gift_ks_pkg.sv
// Shared definitions for the GIFT-128 round-key sequencer: FSM states, sizing
// constants and the per-word key update functions.
package gift_ks_pkg;

  localparam int unsigned NROUNDS_DEF = 40;
  localparam int unsigned RoundW      = 6;

  typedef enum logic [1:0] {
    StIdle,
    StFfwd,
    StEmit
  } ks_state_e;

  // Low half rotl 4, high half rotr 2 (each within 16 bits).
  function automatic logic [31:0] kw_upd(input logic [31:0] x);
    return {x[17:16], x[31:18], x[11:0], x[15:12]};
  endfunction

  // Exact inverse of kw_upd: low half rotr 4, high half rotl 2.
  function automatic logic [31:0] kw_inv(input logic [31:0] x);
    return {x[29:16], x[31:30], x[3:0], x[15:4]};
  endfunction

endpackage

// File: rtl/gift_kw_rot.sv
// Combinational key-word rotator: forward update or its inverse, chosen by i_inv.
module gift_kw_rot
  import gift_ks_pkg::*;
(
  input  logic        i_inv,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_inv ? kw_inv(i_word) : kw_upd(i_word);
  end

endmodule

// File: rtl/gift_rkey_seq.sv
// GIFT-128 round-key sequencer: loads a master key, then streams round keys in
// forward order or, after an internal fast-forward, in reverse order.
module gift_rkey_seq
  import gift_ks_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [127:0]      key_in,
  input  logic              key_dir,
  input  logic              abort,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [31:0]       rk_u,
  output logic [31:0]       rk_v,
  output logic [RoundW-1:0] rk_round,
  output logic              rk_last
);

  localparam int unsigned FfwdLastI = (NROUNDS > 1) ? NROUNDS - 2 : 0;
  localparam logic [RoundW-1:0] LastRound = RoundW'(NROUNDS - 1);
  localparam logic [RoundW-1:0] FfwdLast  = RoundW'(FfwdLastI);

  ks_state_e         r_state;
  logic [127:0]      r_key;
  logic              r_dir;
  logic [RoundW-1:0] r_cnt;

  logic              w_use_inv;
  logic [31:0]       w_rot_in;
  logic [31:0]       w_rot_out;
  logic [127:0]      w_key_next;
  logic              w_last;

  // Only a reverse-order EMIT walks the schedule backwards; FFWD always steps forward.
  always_comb begin
    w_use_inv = (r_state == StEmit) && r_dir;
    w_rot_in  = w_use_inv ? r_key[127:96] : r_key[31:0];
  end

  gift_kw_rot u_rot (
    .i_inv  (w_use_inv),
    .i_word (w_rot_in),
    .o_word (w_rot_out)
  );

  always_comb begin
    if (w_use_inv) begin
      w_key_next = {r_key[95:0], w_rot_out};
    end else begin
      w_key_next = {w_rot_out, r_key[127:32]};
    end
  end

  always_comb begin
    w_last = (r_state == StEmit) && (r_dir ? (r_cnt == '0) : (r_cnt == LastRound));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_key   <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
    end else if (abort) begin
      r_state <= StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (key_valid) begin
            r_key <= key_in;
            r_dir <= key_dir;
            r_cnt <= '0;
            if (key_dir && (NROUNDS > 1)) begin
              r_state <= StFfwd;
            end else begin
              r_state <= StEmit;
            end
          end
        end
        StFfwd: begin
          r_key <= w_key_next;
          r_cnt <= r_cnt + RoundW'(1);
          if (r_cnt == FfwdLast) begin
            r_state <= StEmit;
          end
        end
        StEmit: begin
          if (rk_ready) begin
            if (w_last) begin
              r_state <= StIdle;
            end else if (r_dir) begin
              r_key <= w_key_next;
              r_cnt <= r_cnt - RoundW'(1);
            end else begin
              r_key <= w_key_next;
              r_cnt <= r_cnt + RoundW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; no path from rk_ready or key_valid.
  always_comb begin
    key_ready = (r_state == StIdle);
    rk_valid  = (r_state == StEmit);
    rk_u      = r_key[95:64];
    rk_v      = r_key[31:0];
    rk_round  = r_cnt;
    rk_last   = w_last;
  end

endmodule

// File: tb/tb_gift_rkey_seq.sv
// Directed bench for gift_rkey_seq: forward/reverse streams, backpressure, abort, reset.
module tb_gift_rkey_seq;

  localparam int NR = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         key_dir;
  logic         abort;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_u;
  logic [31:0]  rk_v;
  logic [5:0]   rk_round;
  logic         rk_last;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] m_u [0:NR-1];
  logic [31:0] m_v [0:NR-1];
  logic [31:0] got_u [0:NR-1];
  logic [31:0] got_v [0:NR-1];

  gift_rkey_seq #(
    .NROUNDS (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .key_dir   (key_dir),
    .abort     (abort),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_u      (rk_u),
    .rk_v      (rk_v),
    .rk_round  (rk_round),
    .rk_last   (rk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference schedule: round r = W2/W0 after r forward steps.
  task automatic build_model(input logic [127:0] key);
    logic [127:0] s;
    logic [31:0]  w0;
    s = key;
    for (int r = 0; r < NR; r++) begin
      m_u[r] = s[95:64];
      m_v[r] = s[31:0];
      w0 = s[31:0];
      s = {{w0[17:16], w0[31:18], w0[11:0], w0[15:12]}, s[127:32]};
    end
  endtask

  task automatic run_sched(input logic [127:0] key, input logic dir, input logic bp);
    int          wait_n;
    int          hs;
    int          guard;
    int          exp_r;
    logic        stalled;
    logic [71:0] held;
    build_model(key);
    chk("ready_before_load", key_ready, 1);
    key_in    = key;
    key_dir   = dir;
    key_valid = 1'b1;
    rk_ready  = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    wait_n = 0;
    while (!rk_valid && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("first_valid_latency", wait_n, dir ? NR - 1 : 0);
    hs      = 0;
    guard   = 0;
    exp_r   = dir ? NR - 1 : 0;
    stalled = 1'b0;
    held    = '0;
    while (hs < NR && guard < 2000) begin
      if (stalled) chk("stall_hold", {rk_valid, rk_last, rk_round, rk_u, rk_v}, held);
      if (!rk_valid) begin
        chk("valid_in_stream", rk_valid, 1);
        break;
      end
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready) begin
        chk("hs_round", rk_round, exp_r);
        chk("hs_u", rk_u, m_u[exp_r]);
        chk("hs_v", rk_v, m_v[exp_r]);
        chk("hs_last", rk_last, dir ? (exp_r == 0) : (exp_r == NR - 1));
        got_u[exp_r] = rk_u;
        got_v[exp_r] = rk_v;
        hs++;
        exp_r   = dir ? exp_r - 1 : exp_r + 1;
        stalled = 1'b0;
      end else begin
        held    = {rk_valid, rk_last, rk_round, rk_u, rk_v};
        stalled = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    rk_ready = 1'b0;
    chk("hs_count", hs, NR);
    chk("idle_after_last", {key_ready, rk_valid}, 2'b10);
  endtask

  localparam logic [127:0] Key1 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] Key2 = 128'h0000_0000_0000_0000_0000_0000_0001_0000;
  localparam logic [127:0] Key3 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] Key4 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;

  initial begin
    int seen;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    key_dir   = 1'b0;
    abort     = 1'b0;
    rk_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {key_ready, rk_valid, rk_last, rk_round, rk_u, rk_v}, {3'b100, 70'd0});
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a forward stream.
    key_in    = Key1;
    key_dir   = 1'b0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_emit", {rk_valid, rk_round}, {1'b1, 6'd3});
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rk_ready = 1'b0;
    chk("mid_reset", {key_ready, rk_valid, rk_round, rk_u, rk_v}, {2'b10, 70'd0});

    run_sched(Key1, 1'b0, 1'b0);
    chk("fwd_r0_v", got_v[0], 32'h0000_0001);
    chk("fwd_r4_v", got_v[4], 32'h0000_0010);
    chk("fwd_r8_v", got_v[8], 32'h0000_0100);
    chk("fwd_r12_v", got_v[12], 32'h0000_1000);
    chk("fwd_r16_v", got_v[16], 32'h0000_0001);
    chk("fwd_r2_u", got_u[2], 32'h0000_0010);

    run_sched(Key1, 1'b1, 1'b0);
    chk("rev_r0_v", got_v[0], 32'h0000_0001);
    chk("rev_r0_u", got_u[0], 32'h0000_0000);

    run_sched(Key2, 1'b0, 1'b0);
    chk("hi_fwd_r4_v", got_v[4], 32'h4000_0000);
    run_sched(Key2, 1'b1, 1'b0);
    chk("hi_rev_r0_v", got_v[0], 32'h0001_0000);

    run_sched(Key3, 1'b0, 1'b1);
    run_sched(Key3, 1'b1, 1'b1);

    // Abort during fast-forward.
    key_in    = Key1;
    key_dir   = 1'b1;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("ffwd_busy", {key_ready, rk_valid}, 2'b00);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ffwd_idle", {key_ready, rk_valid}, 2'b10);
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (rk_valid) seen++;
    end
    chk("abort_ffwd_no_valid", seen, 0);

    // Abort coincident with a handshake: no step taken.
    key_in    = Key4;
    key_dir   = 1'b0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("abort_hs_pre", {rk_valid, rk_round, rk_v}, {1'b1, 6'd0, 32'h1});
    rk_ready = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    rk_ready = 1'b0;
    chk("abort_hs_idle", {key_ready, rk_valid}, 2'b10);
    chk("abort_hs_nostep", {rk_round, rk_u, rk_v}, {6'd0, 32'h3, 32'h1});

    // Abort and key_valid together in IDLE: key dropped.
    key_in    = Key3;
    key_dir   = 1'b0;
    key_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    abort     = 1'b0;
    chk("idle_abort_key_drop", {key_ready, rk_valid, rk_v}, {2'b10, 32'h1});
    @(negedge clk);
    chk("idle_abort_still_idle", {key_ready, rk_valid}, 2'b10);

    run_sched(Key4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
